psram_arb: RTL and testbench
============================

Name: psram_arb

Overview:
- Two-requester arbiter/sequencer for one PSRAM chip (PSR0 or PSR1 byte port; instantiated once per chip).
- Shares the chip between the console CPU bus window (cpu_ce phase signal plus OE/WE strobes) and an MCU/DMA master using a req/ack handshake.
- Generates the chip strobes (ce/oe/we) with fixed access and recovery timing, and returns read data to the winner.
- Sits between the everdrive core's CPU decode and the top-level PSRAM pin assigns.

Parameters:
- ACC_CYC, 6, clk cycles from strobe assertion to read-data sample / write strobe end (3..15).
- REC_CYC, 2, cycles with ce deasserted between any two accesses (1..7).
- AW, 24, byte address width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  async active-low reset
- cpu_ce  in  1  CPU access window (async to clk; synchronised internally)
- cpu_oe_n  in  1  CPU read strobe (async)
- cpu_we_n  in  1  CPU write strobe (async)
- cpu_addr  in  AW  CPU byte address, stable while cpu_ce high
- cpu_wdat  in  8  CPU write data
- cpu_rdat  out  8  CPU read data, registered
- dma_req  in  1  DMA request, level; hold until ack
- dma_we  in  1  1=write, 0=read
- dma_addr  in  AW  DMA byte address
- dma_wdat  in  8  DMA write data
- dma_rdat  out  8  DMA read data, valid in the cycle dma_ack=1
- dma_ack  out  1  one-cycle completion pulse
- mem_addr  out  AW  PSRAM byte address
- mem_dati  out  8  data to PSRAM
- mem_dato  in  8  data from PSRAM
- mem_ce  out  1  chip enable, active high
- mem_oe  out  1  output enable, active high
- mem_we  out  1  write enable, active high

Behaviour:
- Reset: all outputs 0, including mem_addr, cpu_rdat and dma_rdat; FSM in IDLE; synchronisers cleared.
- cpu_ce, cpu_oe_n and cpu_we_n pass through 2-flop synchronisers. cpu_go = rising edge of the synchronised cpu_ce.
- FSM states: IDLE, CPU_RD, CPU_WR, CPU_HOLD, DMA_ACC, REC.
- IDLE priority:
  - cpu_go, or a latched pending-CPU flag, wins.
  - Else dma_req.
  - A CPU request arriving while DMA_ACC or REC is active sets the pending flag; it is served on return to IDLE.
  - DMA cannot be starved: it runs whenever cpu_ce is low.
- CPU entry: capture cpu_addr into mem_addr. If synchronised cpu_we_n=0, go to CPU_WR; else CPU_RD.
- CPU_RD:
  - Entry cycle: mem_ce=1, mem_oe=1.
  - Cycle ACC_CYC: cpu_rdat <= mem_dato.
  - Then CPU_HOLD with mem_ce and mem_oe held until synchronised cpu_ce falls, so the bus stays valid for the console.
- CPU_WR:
  - mem_dati <= cpu_wdat on entry.
  - mem_ce=1 and mem_we=1 for ACC_CYC cycles, then mem_we=0.
  - Then CPU_HOLD with mem_ce=1 until cpu_ce falls.
- Late write: a write strobe seen only after entering CPU_RD (cpu_we_n falls during CPU_HOLD) restarts as CPU_WR at the same address. This happens once per window.
- DMA_ACC:
  - Latch dma_addr, dma_we and dma_wdat; assert mem_ce together with mem_oe or mem_we.
  - At cycle ACC_CYC: capture dma_rdat if a read, pulse dma_ack, go to REC.
- REC: all strobes 0 for REC_CYC cycles, then IDLE. Every exit from CPU_HOLD also passes through REC.
- mem_oe and mem_we are never both 1. mem_ce=0 in IDLE and REC.
- The access counter is 4 bits wide and saturates; it is never compared past ACC_CYC.
- dma_req dropped before ack: the access still completes, but dma_ack is suppressed.
- Simultaneous cpu_go and dma_req in IDLE: CPU wins; DMA waits.
- Async reset mid-access drops all strobes immediately and discards the pending flag.

Optional Feature:
- Macro: PSRAM_ARB_STATS_EN.
- Defined:
  - Adds out ports cpu_cnt[15:0] and dma_wait[15:0].
  - cpu_cnt: saturating count of CPU accesses.
  - dma_wait: saturating count of cycles with dma_req=1 and no ack.
  - Both clear on reset.
- Undefined: ports absent; timing and behaviour otherwise identical.

Decomposition:
- Package psram_arb_pkg: state enum (IDLE, CPU_RD, CPU_WR, CPU_HOLD, DMA_ACC, REC) and default ACC_CYC/REC_CYC constants.
- One sub-module, psram_arb_sync: 3-signal 2-flop synchroniser with rising-edge detect for cpu_ce.
- FSM, timing counter and optional stats counters live in psram_arb.

Test Plan:
- CPU read, addr 0x012345, mem model returns 0xA5 → mem_ce/mem_oe rise 3 clk after cpu_ce; cpu_rdat=0xA5; strobes drop 3 clk after cpu_ce falls; REC 2 clk.
- CPU write 0x5A to 0x000010 → mem_we high exactly 6 clk with mem_dati=0x5A; mem_oe stays 0 throughout.
- DMA read 0x7FFFFF, data 0x3C → dma_ack one cycle at cycle 6 after ce, with dma_rdat=0x3C; ce low for 2 clk afterwards.
- cpu_ce rises during DMA_ACC cycle 2 → DMA completes and acks; after REC, CPU access starts; no cycle with overlapping strobes.
- Simultaneous cpu_go and dma_req → CPU served first; dma_ack follows after CPU_HOLD plus REC.
- rst_n asserted mid CPU_WR → mem_we/mem_ce go 0 asynchronously; post-reset DMA write completes normally (with STATS_EN defined, cpu_cnt=0).

Source files
------------

// File: rtl/psram_arb_pkg.sv
// Shared types and default timing for the PSRAM arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package psram_arb_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CPU_RD   = 3'd1,
        CPU_WR   = 3'd2,
        CPU_HOLD = 3'd3,
        DMA_ACC  = 3'd4,
        REC      = 3'd5
    } state_t;

    localparam int ACC_CYC_DEF = 6;
    localparam int REC_CYC_DEF = 2;

endpackage

// File: rtl/psram_arb_sync.sv
// Two-flop synchroniser for the console strobes plus cpu_ce rising-edge detect.
// Latency: 2 clk to the synchronised levels, ce_rise valid in the cycle after that.
// Backpressure: none; free-running sampler.
module psram_arb_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic ce_a,
    input  logic oe_n_a,
    input  logic we_n_a,
    output logic ce_s,
    output logic oe_n_s,
    output logic we_n_s,
    output logic ce_rise
);

    logic [2:0] meta;
    logic [2:0] sync;
    logic       ce_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            sync <= '0;
            ce_d <= 1'b0;
        end else begin
            meta <= {ce_a, oe_n_a, we_n_a};
            sync <= meta;
            ce_d <= sync[2];
        end
    end

    assign ce_s    = sync[2];
    assign oe_n_s  = sync[1];
    assign we_n_s  = sync[0];
    assign ce_rise = sync[2] & ~ce_d;

endmodule

// File: rtl/psram_arb.sv
// Shares one PSRAM between the console CPU window and a DMA master; optional stats via PSRAM_ARB_STATS_EN.
// Latency: strobes ACC_CYC clk per access, REC_CYC clk recovery; CPU start 3 clk after cpu_ce rises.
// Backpressure: DMA holds dma_req until dma_ack; a CPU window arriving while busy is latched and served next.
module psram_arb
    import psram_arb_pkg::*;
#(
    parameter int ACC_CYC = ACC_CYC_DEF,
    parameter int REC_CYC = REC_CYC_DEF,
    parameter int AW      = 24
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_ce,
    input  logic          cpu_oe_n,
    input  logic          cpu_we_n,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_wdat,
    output logic [7:0]    cpu_rdat,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [7:0]    dma_wdat,
    output logic [7:0]    dma_rdat,
    output logic          dma_ack,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_dati,
    input  logic [7:0]    mem_dato,
    output logic          mem_ce,
    output logic          mem_oe,
    output logic          mem_we
`ifdef PSRAM_ARB_STATS_EN
    ,
    output logic [15:0]   cpu_cnt,
    output logic [15:0]   dma_wait
`endif
);

    localparam logic [3:0] ACC_C = 4'(ACC_CYC);
    localparam logic [3:0] REC_C = 4'(REC_CYC);

    state_t     state;
    logic [3:0] cnt;
    logic       pend;
    logic       late_done;
    logic       ce_s, oe_n_s, we_n_s, cpu_go;
    logic       cpu_start;

    psram_arb_sync u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .ce_a    (cpu_ce),
        .oe_n_a  (cpu_oe_n),
        .we_n_a  (cpu_we_n),
        .ce_s    (ce_s),
        .oe_n_s  (oe_n_s),
        .we_n_s  (we_n_s),
        .ce_rise (cpu_go)
    );

    assign cpu_start = (state == IDLE) && (cpu_go || pend);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            pend      <= 1'b0;
            late_done <= 1'b0;
            mem_addr  <= '0;
            mem_dati  <= '0;
            mem_ce    <= 1'b0;
            mem_oe    <= 1'b0;
            mem_we    <= 1'b0;
            cpu_rdat  <= '0;
            dma_rdat  <= '0;
            dma_ack   <= 1'b0;
        end else begin
            dma_ack <= 1'b0;
            cnt     <= (cnt == 4'hF) ? cnt : cnt + 4'd1;
            // A window opening while the chip is busy is remembered, not dropped
            if (cpu_go && state != IDLE)
                pend <= 1'b1;
            case (state)
                IDLE: begin
                    if (cpu_start) begin
                        pend      <= 1'b0;
                        late_done <= 1'b0;
                        mem_addr  <= cpu_addr;
                        mem_ce    <= 1'b1;
                        cnt       <= 4'd1;
                        if (!we_n_s) begin
                            state    <= CPU_WR;
                            mem_we   <= 1'b1;
                            mem_dati <= cpu_wdat;
                        end else begin
                            state  <= CPU_RD;
                            mem_oe <= 1'b1;
                        end
                    end else if (dma_req) begin
                        state    <= DMA_ACC;
                        mem_addr <= dma_addr;
                        mem_dati <= dma_wdat;
                        mem_ce   <= 1'b1;
                        mem_we   <= dma_we;
                        mem_oe   <= ~dma_we;
                        cnt      <= 4'd1;
                    end
                end
                CPU_RD: begin
                    if (cnt == ACC_C) begin
                        cpu_rdat <= mem_dato;
                        state    <= CPU_HOLD;
                    end
                end
                CPU_WR: begin
                    if (cnt == ACC_C) begin
                        mem_we <= 1'b0;
                        state  <= CPU_HOLD;
                    end
                end
                CPU_HOLD: begin
                    if (!ce_s) begin
                        state  <= REC;
                        mem_ce <= 1'b0;
                        mem_oe <= 1'b0;
                        mem_we <= 1'b0;
                        cnt    <= 4'd1;
                    end else if (mem_oe && !late_done && !we_n_s && oe_n_s) begin
                        // Console turned a read window into a write: redo it as a write once
                        state     <= CPU_WR;
                        mem_oe    <= 1'b0;
                        mem_we    <= 1'b1;
                        mem_dati  <= cpu_wdat;
                        late_done <= 1'b1;
                        cnt       <= 4'd1;
                    end
                end
                DMA_ACC: begin
                    if (cnt == ACC_C) begin
                        if (mem_oe)
                            dma_rdat <= mem_dato;
                        dma_ack <= dma_req;
                        mem_ce  <= 1'b0;
                        mem_oe  <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= REC;
                        cnt     <= 4'd1;
                    end
                end
                REC: begin
                    if (cnt == REC_C)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PSRAM_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_cnt  <= '0;
            dma_wait <= '0;
        end else begin
            if (cpu_start && cpu_cnt != 16'hFFFF)
                cpu_cnt <= cpu_cnt + 16'd1;
            if (dma_req && !dma_ack && dma_wait != 16'hFFFF)
                dma_wait <= dma_wait + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_psram_arb.sv
// Bench for psram_arb: vector table, corner sequences and random ops against a memory reference.
// Latency: n/a.
// Backpressure: n/a.
module tb_psram_arb;

    localparam int ACC = 6;
    localparam int REC = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_ce = 1'b0, cpu_oe_n = 1'b1, cpu_we_n = 1'b1;
    logic [23:0] cpu_addr = '0;
    logic [7:0]  cpu_wdat = '0;
    logic [7:0]  cpu_rdat;
    logic        dma_req = 1'b0, dma_we = 1'b0;
    logic [23:0] dma_addr = '0;
    logic [7:0]  dma_wdat = '0;
    logic [7:0]  dma_rdat;
    logic        dma_ack;
    logic [23:0] mem_addr;
    logic [7:0]  mem_dati;
    logic [7:0]  mem_dato = '0;
    logic        mem_ce, mem_oe, mem_we;
`ifdef PSRAM_ARB_STATS_EN
    logic [15:0] cpu_cnt, dma_wait;
`endif

    psram_arb dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_ce(cpu_ce), .cpu_oe_n(cpu_oe_n), .cpu_we_n(cpu_we_n),
        .cpu_addr(cpu_addr), .cpu_wdat(cpu_wdat), .cpu_rdat(cpu_rdat),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wdat(dma_wdat), .dma_rdat(dma_rdat), .dma_ack(dma_ack),
        .mem_addr(mem_addr), .mem_dati(mem_dati), .mem_dato(mem_dato),
        .mem_ce(mem_ce), .mem_oe(mem_oe), .mem_we(mem_we)
`ifdef PSRAM_ARB_STATS_EN
        , .cpu_cnt(cpu_cnt), .dma_wait(dma_wait)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_chk = 0, n_pass = 0;
    int overlap = 0, ack_cnt = 0;

    // Chip contents as seen on the pins, and the expected contents from the op stream
    logic [7:0] chip_mem [logic [23:0]];
    logic [7:0] ref_mem  [logic [23:0]];

    function automatic logic [7:0] dflt(input logic [23:0] a);
        return a[7:0] ^ a[23:16] ^ 8'h96;
    endfunction

    function automatic logic [7:0] chip_rd(input logic [23:0] a);
        return chip_mem.exists(a) ? chip_mem[a] : dflt(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [23:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    always @(negedge clk) begin
        if (mem_oe && mem_we) overlap++;
        if ((mem_oe || mem_we) && !mem_ce) overlap++;
        if (dma_ack) ack_cnt++;
        if (mem_ce && mem_we) chip_mem[mem_addr] = mem_dati;
        mem_dato <= chip_rd(mem_addr);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_op(input bit wr, input logic [23:0] a, input logic [7:0] wd,
                          output logic [7:0] rd, output int rise_lat, output int we_len,
                          output int fall_lat, output int bad);
        int n, t;
        bad = 0;
        cpu_addr = a; cpu_wdat = wd; cpu_we_n = !wr; cpu_oe_n = wr; cpu_ce = 1'b1;
        t = cyc;
        n = 0;
        while (!mem_ce && n < 100) begin tick(); n++; end
        rise_lat = cyc - t;
        if (mem_addr !== a) bad++;
        we_len = 0;
        for (int i = 0; i < ACC + 6; i++) begin
            if (!mem_ce) bad++;
            if (wr) begin
                if (mem_we) we_len++;
                if (mem_we && mem_dati !== wd) bad++;
                if (mem_oe) bad++;
            end else if (!mem_oe || mem_we) bad++;
            tick();
        end
        rd = cpu_rdat;
        cpu_ce = 1'b0; cpu_we_n = 1'b1; cpu_oe_n = 1'b1;
        t = cyc;
        n = 0;
        while (mem_ce && n < 100) begin tick(); n++; end
        fall_lat = cyc - t;
        if (wr) ref_mem[a] = wd;
    endtask

    task automatic dma_op(input bit wr, input logic [23:0] a, input logic [7:0] wd,
                          output logic [7:0] rd, output int ack_lat, output int bad);
        int n, t, a0;
        bad = 0;
        a0 = ack_cnt;
        dma_we = wr; dma_addr = a; dma_wdat = wd; dma_req = 1'b1;
        n = 0;
        while (!mem_ce && n < 200) begin tick(); n++; end
        if (mem_addr !== a || mem_we !== wr || mem_oe !== !wr) bad++;
        t = cyc;
        n = 0;
        while (!dma_ack && n < 200) begin tick(); n++; end
        ack_lat = cyc - t;
        rd = dma_rdat;
        dma_req = 1'b0;
        tick();
        if (dma_ack) bad++;
        if (ack_cnt - a0 != 1) bad++;
        if (wr) ref_mem[a] = wd;
    endtask

    typedef struct {
        bit          dma;
        bit          wr;
        logic [23:0] addr;
        logic [7:0]  wdat;
        logic [7:0]  exp;
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        vt [10];
        logic [7:0]  rd;
        int          l1, l2, l3, bad, n, t, a0;
        logic [23:0] ra;
        logic [7:0]  rw;
        bit          rdma, rwr;

        chip_mem[24'h012345] = 8'hA5; ref_mem[24'h012345] = 8'hA5;
        chip_mem[24'h7FFFFF] = 8'h3C; ref_mem[24'h7FFFFF] = 8'h3C;

        vt[0] = '{1'b0, 1'b0, 24'h012345, 8'h00, 8'hA5};
        vt[1] = '{1'b1, 1'b0, 24'h7FFFFF, 8'h00, 8'h3C};
        vt[2] = '{1'b0, 1'b1, 24'h000010, 8'h5A, 8'h00};
        vt[3] = '{1'b1, 1'b0, 24'h000010, 8'h00, 8'h5A};
        vt[4] = '{1'b1, 1'b1, 24'h000200, 8'hC3, 8'h00};
        vt[5] = '{1'b0, 1'b0, 24'h000200, 8'h00, 8'hC3};
        vt[6] = '{1'b1, 1'b1, 24'hFFFFFF, 8'h81, 8'h00};
        vt[7] = '{1'b0, 1'b0, 24'hFFFFFF, 8'h00, 8'h81};
        vt[8] = '{1'b0, 1'b1, 24'h800000, 8'h00, 8'h00};
        vt[9] = '{1'b1, 1'b0, 24'h800000, 8'h00, 8'h00};

        // Reset state
        repeat (3) tick();
        chk("rst_strobes", {mem_ce, mem_oe, mem_we, dma_ack}, 4'b0000);
        chk("rst_mem_addr", mem_addr, 24'h0);
        chk("rst_rdat", {cpu_rdat, dma_rdat, mem_dati}, 24'h0);
        rst_n = 1'b1;
        repeat (3) tick();

        // Vector table
        for (int i = 0; i < 10; i++) begin
            if (vt[i].dma) begin
                dma_op(vt[i].wr, vt[i].addr, vt[i].wdat, rd, l1, bad);
                chk($sformatf("vec%0d_ack_lat", i), l1, ACC);
                chk($sformatf("vec%0d_dma_proto", i), bad, 0);
                if (!vt[i].wr) chk($sformatf("vec%0d_dma_rdat", i), rd, vt[i].exp);
            end else begin
                cpu_op(vt[i].wr, vt[i].addr, vt[i].wdat, rd, l1, l2, l3, bad);
                chk($sformatf("vec%0d_ce_rise", i), l1, 3);
                chk($sformatf("vec%0d_ce_fall", i), l3, 3);
                chk($sformatf("vec%0d_cpu_proto", i), bad, 0);
                if (vt[i].wr) chk($sformatf("vec%0d_we_len", i), l2, ACC);
                else chk($sformatf("vec%0d_cpu_rdat", i), rd, vt[i].exp);
            end
            repeat (4) tick();
        end

        // Simultaneous cpu_go and dma_req: CPU first, DMA after hold + recovery
        a0 = ack_cnt;
        cpu_addr = 24'h012345; cpu_oe_n = 1'b0; cpu_we_n = 1'b1; cpu_ce = 1'b1;
        tick(); tick();
        dma_addr = 24'h7FFFFF; dma_we = 1'b0; dma_req = 1'b1;
        n = 0;
        while (!mem_ce && n < 50) begin tick(); n++; end
        chk("sim_cpu_first", {mem_oe, mem_addr}, {1'b1, 24'h012345});
        repeat (ACC + 4) tick();
        chk("sim_dma_waits", ack_cnt - a0, 0);
        chk("sim_cpu_rdat", cpu_rdat, 8'hA5);
        cpu_ce = 1'b0; cpu_oe_n = 1'b1;
        t = cyc;
        n = 0;
        while (!dma_ack && n < 100) begin tick(); n++; end
        chk("sim_ack_delay", cyc - t, 3 + REC + 1 + ACC);
        chk("sim_dma_rdat", dma_rdat, 8'h3C);
        dma_req = 1'b0;
        repeat (4) tick();

        // CPU window opens in DMA cycle 2: DMA finishes, then CPU is served
        dma_addr = 24'h000010; dma_we = 1'b0; dma_req = 1'b1;
        n = 0;
        while (!mem_ce && n < 50) begin tick(); n++; end
        tick();
        cpu_addr = 24'h000200; cpu_oe_n = 1'b0; cpu_we_n = 1'b1; cpu_ce = 1'b1;
        n = 0;
        while (!dma_ack && n < 50) begin tick(); n++; end
        chk("pend_dma_ack", {dma_ack, dma_rdat}, {1'b1, 8'h5A});
        dma_req = 1'b0;
        n = 0;
        while (!mem_ce && n < 50) begin tick(); n++; end
        chk("pend_cpu_served", {mem_oe, mem_addr}, {1'b1, 24'h000200});
        repeat (ACC + 2) tick();
        chk("pend_cpu_rdat", cpu_rdat, 8'hC3);
        cpu_ce = 1'b0; cpu_oe_n = 1'b1;
        repeat (8) tick();

        // Back-to-back DMA: recovery gap then the next access
        dma_addr = 24'h600000; dma_we = 1'b1; dma_wdat = 8'h42; dma_req = 1'b1;
        n = 0;
        while (!dma_ack && n < 50) begin tick(); n++; end
        t = cyc;
        dma_we = 1'b0;
        n = 0;
        while (!mem_ce && n < 50) begin tick(); n++; end
        chk("b2b_ce_gap", cyc - t, REC + 1);
        n = 0;
        while (!dma_ack && n < 50) begin tick(); n++; end
        chk("b2b_readback", dma_rdat, 8'h42);
        dma_req = 1'b0;
        repeat (4) tick();

        // Request withdrawn mid-access: access completes, no ack
        a0 = ack_cnt;
        dma_addr = 24'h000500; dma_we = 1'b0; dma_req = 1'b1;
        n = 0;
        while (!mem_ce && n < 50) begin tick(); n++; end
        tick(); tick();
        dma_req = 1'b0;
        repeat (ACC + 4) tick();
        chk("drop_no_ack", ack_cnt - a0, 0);
        chk("drop_ce_released", mem_ce, 1'b0);

        // Late write inside a read window, only once
        cpu_addr = 24'h000400; cpu_oe_n = 1'b0; cpu_we_n = 1'b1; cpu_ce = 1'b1;
        n = 0;
        while (!mem_ce && n < 50) begin tick(); n++; end
        repeat (ACC + 2) tick();
        cpu_oe_n = 1'b1; cpu_we_n = 1'b0; cpu_wdat = 8'h77;
        n = 0;
        while (!mem_we && n < 20) begin tick(); n++; end
        chk("late_we_start", {mem_we, mem_oe, mem_addr}, {2'b10, 24'h000400});
        n = 0;
        while (mem_we && n < 40) begin tick(); n++; end
        chk("late_we_len", n, ACC);
        cpu_we_n = 1'b1;
        repeat (4) tick();
        cpu_we_n = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (mem_we) n++;
            tick();
        end
        chk("late_once", n, 0);
        cpu_ce = 1'b0; cpu_we_n = 1'b1;
        ref_mem[24'h000400] = 8'h77;
        repeat (8) tick();
        dma_op(1'b0, 24'h000400, 8'h00, rd, l1, bad);
        chk("late_readback", rd, 8'h77);

        // Async reset in the middle of a CPU write
        repeat (4) tick();
        cpu_addr = 24'h300000; cpu_wdat = 8'h11; cpu_we_n = 1'b0; cpu_oe_n = 1'b1; cpu_ce = 1'b1;
        n = 0;
        while (!mem_we && n < 50) begin tick(); n++; end
        tick(); tick();
        #2 rst_n = 1'b0;
        #1 chk("rst_mid_strobes", {mem_ce, mem_we, mem_oe}, 3'b000);
        cpu_ce = 1'b0; cpu_we_n = 1'b1;
        tick(); tick();
        rst_n = 1'b1;
        repeat (3) tick();
        dma_op(1'b1, 24'h300001, 8'hE7, rd, l1, bad);
        chk("post_rst_dma_wr", {l1, bad}, {ACC, 32'd0});
        dma_op(1'b0, 24'h300001, 8'h00, rd, l1, bad);
        chk("post_rst_dma_rd", rd, 8'hE7);
`ifdef PSRAM_ARB_STATS_EN
        chk("post_rst_cpu_cnt", cpu_cnt, 16'd0);
`endif

        // Random op stream against the memory reference
        for (int i = 0; i < 40; i++) begin
            rdma = 1'($urandom_range(0, 1));
            rwr  = 1'($urandom_range(0, 1));
            ra   = 24'h100000 + 24'($urandom_range(0, 7));
            rw   = 8'($urandom);
            if (rdma) begin
                dma_op(rwr, ra, rw, rd, l1, bad);
                chk($sformatf("rnd%0d_dma", i), {l1, bad}, {ACC, 32'd0});
            end else begin
                cpu_op(rwr, ra, rw, rd, l1, l2, l3, bad);
                chk($sformatf("rnd%0d_cpu", i), bad, 0);
            end
            if (!rwr) chk($sformatf("rnd%0d_rdat", i), rd, ref_rd(ra));
            repeat ($urandom_range(0, 3)) tick();
        end

        chk("no_overlap", overlap, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
